// File: rtl/stream_mux_2_1.sv
// stream_mux_2_1: round-robin 2:1 valid/ready merge, registered output, source tag.
// Optional packet lock (STREAM_MUX_PKT_LOCK_EN) keeps a multi-beat packet contiguous.
module stream_mux_2_1 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  input  logic          in1_valid,
  output logic          in1_ready,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sel,
  output logic          out_last
);

  logic          load;
  logic [1:0]    req;
  logic          gnt_vld;
  logic          gnt_idx;
  logic [DW-1:0] gnt_data;
  logic          gnt_last;
  logic          xfer;
  logic          rr;

  assign load = !out_valid || out_ready;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic lock;
  logic lock_idx;

  // While locked, the other input is masked even if the owner is idle.
  always_comb begin
    req = {in1_valid, in0_valid};
    if (lock) begin
      req = lock_idx ? {in1_valid, 1'b0}
                     : {1'b0, in0_valid};
    end
  end
`else
  assign req = {in1_valid, in0_valid};
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    unique case (req)
      2'b01: begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b0;
      end
      2'b10: begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b1;
      end
      2'b11: begin
        gnt_vld = 1'b1;
        gnt_idx = ~rr;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
      end
    endcase
  end

  assign gnt_data = gnt_idx ? in1_data : in0_data;
  assign gnt_last = gnt_idx ? in1_last : in0_last;
  assign xfer     = load && gnt_vld;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign in0_ready = rst_n && xfer && !gnt_idx;
  assign in1_ready = rst_n && xfer && gnt_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
      out_last  <= 1'b0;
      rr        <= 1'b1;
    end else if (load) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= gnt_data;
        out_sel  <= gnt_idx;
        out_last <= gnt_last;
        rr       <= gnt_idx;
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock     <= 1'b0;
      lock_idx <= 1'b0;
    end else if (xfer) begin
      lock     <= !gnt_last;
      lock_idx <= gnt_idx;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_2_1.sv
// tb_stream_mux_2_1: directed stimulus, behavioural model compare every cycle,
// plus literal expectations per scenario.
module tb_stream_mux_2_1;

`ifdef STREAM_MUX_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in0_valid = 1'b0;
  logic       in0_ready;
  logic [7:0] in0_data = '0;
  logic       in0_last = 1'b0;
  logic       in1_valid = 1'b0;
  logic       in1_ready;
  logic [7:0] in1_data = '0;
  logic       in1_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_sel;
  logic       out_last;

  int n_pass = 0;
  int n_tot  = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  always #5 clk = ~clk;

  stream_mux_2_1 #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in0_data(in0_data), .in0_last(in0_last),
    .in1_valid(in1_valid), .in1_ready(in1_ready),
    .in1_data(in1_data), .in1_last(in1_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Model: output slot contents, last winner, packet owner.
  bit         m_v = 0, m_s = 0, m_l = 0, m_lock = 0;
  logic [7:0] m_d = '0;
  int         m_rr = 1, m_li = 0;

  function automatic int winner();
    if (LOCK && m_lock) begin
      if (m_li == 0) return in0_valid ? 0 : -1;
      return in1_valid ? 1 : -1;
    end
    if (in0_valid && in1_valid) return 1 - m_rr;
    if (in0_valid) return 0;
    if (in1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_v = 0; m_d = '0; m_s = 0; m_l = 0;
      m_rr = 1; m_lock = 0; m_li = 0;
    end else if (!m_v || out_ready) begin
      w = winner();
      m_v = (w >= 0);
      if (w >= 0) begin
        m_d = (w == 1) ? in1_data : in0_data;
        m_l = (w == 1) ? in1_last : in0_last;
        m_s = (w == 1);
        m_rr = w;
        m_lock = !m_l;
        m_li = w;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    bit tk;
    if (!rst_n) begin
      check("rst.valid", out_valid, 0);
      check("rst.data", out_data, 0);
      check("rst.rdy", {in1_ready, in0_ready}, 0);
    end else begin
      tk = !m_v || out_ready;
      w = winner();
      check("cmp.valid", out_valid, m_v);
      if (m_v) begin
        check("cmp.data", out_data, m_d);
        check("cmp.sel", out_sel, m_s);
        check("cmp.last", out_last, m_l);
      end
      check("cmp.rdy0", in0_ready, tk && w == 0);
      check("cmp.rdy1", in1_ready, tk && w == 1);
    end
  end

  task automatic drive();
    in0_valid = q0.size() != 0;
    {in0_last, in0_data} = (q0.size() != 0) ? q0[0] : 9'h0;
    in1_valid = q1.size() != 0;
    {in1_last, in1_data} = (q1.size() != 0) ? q1[0] : 9'h0;
  endtask

  task automatic tick();
    bit h0, h1;
    @(negedge clk);
    h0 = in0_valid && in0_ready;
    h1 = in1_valid && in1_ready;
    @(posedge clk);
    #1;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    drive();
  endtask

  task automatic expect_beat(string n, logic [7:0] d, logic s);
    check({n, ".valid"}, out_valid, 1);
    check({n, ".data"}, out_data, d);
    check({n, ".sel"}, out_sel, s);
  endtask

  logic [7:0] lk_d[6] = '{8'hC0, 8'hC1, 8'hC2, 8'hD0, 8'hD1, 8'hD2};
  logic       lk_s[6] = '{0, 0, 0, 1, 1, 1};
  logic [7:0] il_d[6] = '{8'hC0, 8'hD0, 8'hC1, 8'hD1, 8'hC2, 8'hD2};
  logic       il_s[6] = '{0, 1, 0, 1, 0, 1};
  logic [7:0] alt_d[6] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};

  initial begin
    q0.push_back(9'h077);
    drive();
    #1;
    check("reset.rdy0", in0_ready, 0);
    check("reset.valid", out_valid, 0);
    tick();
    tick();
    q0.delete();
    rst_n = 1'b1;
    q1 = '{9'h111, 9'h122, 9'h133};
    drive();
    #1;
    check("single.rdy0", in0_ready, 0);
    tick(); expect_beat("single0", 8'h11, 1);
    check("single.rdy0", in0_ready, 0);
    tick(); expect_beat("single1", 8'h22, 1);
    tick(); expect_beat("single2", 8'h33, 1);
    tick(); check("single.drain", out_valid, 0);

    q0 = '{9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3};
    q1 = '{9'h1B0, 9'h1B1, 9'h1B2, 9'h1B3};
    drive();
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_beat("alt", alt_d[i], 1'(i % 2));
    end
    tick(); tick(); tick();
    check("alt.drain", out_valid, 0);

    q0 = '{9'h15A, 9'h15B};
    drive();
    tick(); expect_beat("bp.first", 8'h5A, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_beat("bp.hold", 8'h5A, 0);
      check("bp.rdy", {in1_ready, in0_ready}, 0);
    end
    out_ready = 1'b1;
    tick(); expect_beat("bp.next", 8'h5B, 0);
    tick(); check("bp.drain", out_valid, 0);

    q1 = '{9'h177};
    drive();
    tick(); expect_beat("lock.pre", 8'h77, 1);
    q0 = '{9'h0C0, 9'h0C1, 9'h1C2};
    q1 = '{9'h1D0, 9'h1D1, 9'h1D2};
    drive();
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_beat("lock", LOCK ? lk_d[i] : il_d[i],
                  LOCK ? lk_s[i] : il_s[i]);
    end
    tick(); check("lock.drain", out_valid, 0);

    q0 = '{9'h1E0, 9'h1E1};
    drive();
    tick(); expect_beat("mid.pre", 8'hE0, 0);
    rst_n = 1'b0;
    #1;
    check("mid.valid", out_valid, 0);
    check("mid.data", out_data, 0);
    check("mid.sel", out_sel, 0);
    check("mid.rdy", {in1_ready, in0_ready}, 0);
    tick();
    q0 = '{9'h1F0};
    q1 = '{9'h1F1};
    rst_n = 1'b1;
    drive();
    tick(); expect_beat("post.first", 8'hF0, 0);
    tick(); expect_beat("post.second", 8'hF1, 1);
    tick(); check("post.drain", out_valid, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
